seg_display_scheduler: RTL and testbench
========================================

// Module: seg_display_scheduler
// PURPOSE
//   Time-shares the 6-digit seven-segment display between NUM_SRC requesters
//   (e.g. PC, ALU result, memory word). Each requester offers 24-bit hex data
//   and 6 digit enables. Sources are granted round-robin for a fixed slot.
//   The block drives the Data/DisplayEnables inputs of the seven-segment scan
//   controller and supplies it a slow scan-enable tick.
// PARAMETERS
//   NUM_SRC      4      number of requesters (2..8)
//   TICK_DIV     50000  Clock cycles per ScanTick (>=2)
//   HOLD_TICKS   1000   ScanTicks a granted source owns the display (>=1)
//   BLANK_TICKS  2      ScanTicks of blank display between slots (>=1)
// PORTS
//   Clock           in   1            system clock
//   Reset           in   1            synchronous, active-high
//   Req             in   NUM_SRC      per-source display request (level)
//   SrcData         in   NUM_SRC*24   source i data at [24*i+23:24*i]
//   SrcEnables      in   NUM_SRC*6    source i digit enables at [6*i+5:6*i]
//   Lock            in   1            hold current grant; suppresses slot expiry
//   Grant           out  NUM_SRC      one-hot owner, 0 when none
//   Data            out  24           registered data to scan controller
//   DisplayEnables  out  6            registered enables; 0 while blank/idle
//   ScanTick        out  1            1-cycle strobe every TICK_DIV cycles
//   Active          out  1            1 in SHOW state
// BEHAVIOUR
//   Reset (sync, priority over all): state IDLE; prescaler, slot counter and
//   blank counter = 0; RR pointer = NUM_SRC-1, so src 0 wins first; Grant=0,
//   Data=0, DisplayEnables=0, ScanTick=0, Active=0.
//   Prescaler: free-running 0..TICK_DIV-1. ScanTick=1 on the cycle after the
//   count equals TICK_DIV-1. Unaffected by state.
//   FSM states:
//   - IDLE: outputs blank. If any Req, pick winner, enter SHOW next cycle.
//   - SHOW: Grant one-hot. Slot counter clears on entry, +1 per ScanTick.
//     Data/DisplayEnables register the granted source every cycle (1-cycle
//     latency, live update). Leave for BLANK when:
//       (a) granted Req=0: exit is the next cycle, with no wait for a tick;
//           Lock does not block it.
//       (b) ScanTick with slot count==HOLD_TICKS-1 and Lock=0.
//     (a)+(b) same cycle: a single transition to BLANK.
//     Lock=1: slot counter saturates at HOLD_TICKS-1.
//   - BLANK: Grant=0, DisplayEnables=0, Data holds its last value.
//     Blank counter +1 per ScanTick. At BLANK_TICKS ticks: any Req -> SHOW
//     with new winner, otherwise IDLE.
//   Arbitration: round-robin search from (ptr+1) mod NUM_SRC over Req; the
//   pointer updates to the winner on SHOW entry. A sole requester is
//   re-granted after each blank gap. Req sampled on the decision cycle only.
//   Counters use $clog2 widths; no overflow (bounded by params).
//   Req deasserted/reasserted during BLANK: no effect until the decision.
// STRUCTURE
//   seg_sched_pkg: state enum {IDLE,SHOW,BLANK}, DIGITS=6, DATA_W=24,
//   SRC_W helper functions.
//   Sub-module seg_rr_pick: combinational round-robin picker.
//   Inputs: req, ptr. Outputs: onehot, index, valid.
//   Prescaler, counters and FSM stay in the top module.
// TESTING (TICK_DIV=4, HOLD_TICKS=3, BLANK_TICKS=1, NUM_SRC=4)
//   1 Reset mid-SHOW -> next cycle Grant=0, DisplayEnables=0, Active=0.
//     Release with Req=4'b1111 -> src0 granted first.
//   2 Req=4'b0101 steady -> Grant 0001 for 12 cycles, 4 blank cycles,
//     0100, blank, 0001, ... strict alternation.
//   3 Req=4'b0010, SrcData1=24'h123456, SrcEnables1=6'h3F
//     -> Data=24'h123456 and DisplayEnables=6'h3F one cycle after Grant.
//     The same source is re-granted after each blank.
//   4 Granted src drops Req mid-slot -> BLANK next cycle, no tick wait.
//     Drop coinciding with slot expiry -> exactly one BLANK period.
//   5 Lock=1 for 40 cycles with Req=4'b1001 -> src0 keeps Grant throughout.
//     Lock release -> BLANK at the next ScanTick, then src3 granted.
//   6 All Req=0 after a BLANK -> IDLE, Grant=0. ScanTick stays period 4
//     in all states.

Source files
------------

// File: rtl/seg_sched_pkg.sv
// Shared definitions for the seven-segment display scheduler.
//   state_e : scheduler FSM states (idle, showing a source, blank gap)
//   DIGITS  : digit count of the display (one enable per digit)
//   DATA_W  : hex data width (4 bits per digit)
//   src_w   : width of an index into n requesters
//   cnt_w   : width of a counter that runs 0..n-1
package seg_sched_pkg;

  localparam int DIGITS = 6;
  localparam int DATA_W = 24;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHOW  = 2'd1,
    ST_BLANK = 2'd2
  } state_e;

  function automatic int src_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/seg_rr_pick.sv
// Combinational round-robin picker.
//   req    : per-source request vector
//   ptr    : index of the previous winner; search starts at ptr+1
//   onehot : one-hot winner, 0 when nobody requests
//   index  : binary winner index (0 when nobody requests)
//   valid  : at least one request present
module seg_rr_pick
  import seg_sched_pkg::*;
#(
  parameter  int NUM_SRC = 4,
  localparam int PW      = src_w(NUM_SRC)
) (
  input  logic [NUM_SRC-1:0] req,
  input  logic [PW-1:0]      ptr,
  output logic [NUM_SRC-1:0] onehot,
  output logic [PW-1:0]      index,
  output logic               valid
);

  // Walk the candidates from farthest to nearest so the nearest requester
  // after ptr is the last one written and therefore wins.
  always_comb begin
    onehot = '0;
    index  = '0;
    valid  = 1'b0;
    for (int k = NUM_SRC; k >= 1; k--) begin
      if (req[(int'(ptr) + k) % NUM_SRC]) begin
        onehot = '0;
        onehot[(int'(ptr) + k) % NUM_SRC] = 1'b1;
        index  = PW'((int'(ptr) + k) % NUM_SRC);
        valid  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/seg_display_scheduler.sv
// Time-shares a 6-digit seven-segment display between NUM_SRC requesters.
// Sources are granted round-robin for HOLD_TICKS scan ticks, separated by a
// blank gap of BLANK_TICKS scan ticks. Also generates the scan-enable tick.
//   Clock, Reset   : clock, synchronous active-high reset
//   Req            : per-source level request
//   SrcData        : source i hex data at [24*i +: 24]
//   SrcEnables     : source i digit enables at [6*i +: 6]
//   Lock           : keep the current owner; suppresses slot expiry only
//   Grant          : one-hot owner, 0 when none
//   Data           : registered data of the owner (holds during blank/idle)
//   DisplayEnables : registered enables of the owner, 0 while blank/idle
//   ScanTick       : one-cycle strobe every TICK_DIV cycles
//   Active         : 1 while a source is being shown
module seg_display_scheduler
  import seg_sched_pkg::*;
#(
  parameter int NUM_SRC     = 4,
  parameter int TICK_DIV    = 50000,
  parameter int HOLD_TICKS  = 1000,
  parameter int BLANK_TICKS = 2
) (
  input  logic                      Clock,
  input  logic                      Reset,
  input  logic [NUM_SRC-1:0]        Req,
  input  logic [NUM_SRC*DATA_W-1:0] SrcData,
  input  logic [NUM_SRC*DIGITS-1:0] SrcEnables,
  input  logic                      Lock,
  output logic [NUM_SRC-1:0]        Grant,
  output logic [DATA_W-1:0]         Data,
  output logic [DIGITS-1:0]         DisplayEnables,
  output logic                      ScanTick,
  output logic                      Active
);

  localparam int PW = src_w(NUM_SRC);
  localparam int TW = cnt_w(TICK_DIV);
  localparam int HW = cnt_w(HOLD_TICKS);
  localparam int BW = cnt_w(BLANK_TICKS);

  state_e               state_q, state_d;
  logic [TW-1:0]        presc_q, presc_d;
  logic                 tick_q, tick_d;
  logic [HW-1:0]        slot_q, slot_d;
  logic [BW-1:0]        blank_q, blank_d;
  logic [PW-1:0]        ptr_q, ptr_d;
  logic [NUM_SRC-1:0]   grant_q, grant_d;
  logic [DATA_W-1:0]    data_q, data_d;
  logic [DIGITS-1:0]    en_q, en_d;

  logic [NUM_SRC-1:0]   pick_onehot;
  logic [PW-1:0]        pick_index;
  logic                 pick_valid;
  logic                 expire;

  seg_rr_pick #(.NUM_SRC(NUM_SRC)) u_pick (
    .req    (Req),
    .ptr    (ptr_q),
    .onehot (pick_onehot),
    .index  (pick_index),
    .valid  (pick_valid)
  );

  // Free-running prescaler; the tick is registered so it appears on the
  // cycle after the count reaches TICK_DIV-1.
  always_comb begin
    presc_d = (presc_q == TW'(TICK_DIV - 1)) ? '0 : presc_q + TW'(1);
    tick_d  = (presc_q == TW'(TICK_DIV - 1));
  end

  always_comb begin
    state_d = state_q;
    slot_d  = slot_q;
    blank_d = blank_q;
    ptr_d   = ptr_q;
    grant_d = grant_q;
    data_d  = data_q;
    en_d    = '0;
    expire  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (pick_valid) begin
          state_d = ST_SHOW;
          grant_d = pick_onehot;
          ptr_d   = pick_index;
          slot_d  = '0;
        end
      end

      ST_SHOW: begin
        // ptr_q always names the current owner while showing.
        data_d = SrcData[int'(ptr_q)*DATA_W +: DATA_W];
        expire = tick_q && (slot_q == HW'(HOLD_TICKS - 1)) && !Lock;
        if (!Req[ptr_q] || expire) begin
          // Enables drop together with Grant so blank never shows digits.
          state_d = ST_BLANK;
          grant_d = '0;
          blank_d = '0;
        end else begin
          en_d = SrcEnables[int'(ptr_q)*DIGITS +: DIGITS];
          // Saturates at the last slot tick; only reachable under Lock.
          if (tick_q && (slot_q != HW'(HOLD_TICKS - 1))) begin
            slot_d = slot_q + HW'(1);
          end
        end
      end

      ST_BLANK: begin
        if (tick_q) begin
          if (blank_q == BW'(BLANK_TICKS - 1)) begin
            if (pick_valid) begin
              state_d = ST_SHOW;
              grant_d = pick_onehot;
              ptr_d   = pick_index;
              slot_d  = '0;
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            blank_d = blank_q + BW'(1);
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= ST_IDLE;
      presc_q <= '0;
      tick_q  <= 1'b0;
      slot_q  <= '0;
      blank_q <= '0;
      ptr_q   <= PW'(NUM_SRC - 1);
      grant_q <= '0;
      data_q  <= '0;
      en_q    <= '0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      tick_q  <= tick_d;
      slot_q  <= slot_d;
      blank_q <= blank_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      data_q  <= data_d;
      en_q    <= en_d;
    end
  end

  assign Grant          = grant_q;
  assign Data           = data_q;
  assign DisplayEnables = en_q;
  assign ScanTick       = tick_q;
  assign Active         = (state_q == ST_SHOW);

endmodule

// File: tb/tb_seg_display_scheduler.sv
// Bench for seg_display_scheduler with TICK_DIV=4, HOLD_TICKS=3,
// BLANK_TICKS=1, NUM_SRC=4: reset checks, a table of grant segments,
// hand-written multi-cycle corner cases and a randomized run against a
// cycle-level reference model.
module tb_seg_display_scheduler;

  localparam int NS = 4;
  localparam int TD = 4;
  localparam int HT = 3;
  localparam int BT = 1;

  logic              Clock;
  logic              Reset;
  logic [NS-1:0]     Req;
  logic [NS*24-1:0]  SrcData;
  logic [NS*6-1:0]   SrcEnables;
  logic              Lock;
  logic [NS-1:0]     Grant;
  logic [23:0]       Data;
  logic [5:0]        DisplayEnables;
  logic              ScanTick;
  logic              Active;

  seg_display_scheduler #(
    .NUM_SRC(NS), .TICK_DIV(TD), .HOLD_TICKS(HT), .BLANK_TICKS(BT)
  ) dut (
    .Clock(Clock), .Reset(Reset), .Req(Req), .SrcData(SrcData),
    .SrcEnables(SrcEnables), .Lock(Lock), .Grant(Grant), .Data(Data),
    .DisplayEnables(DisplayEnables), .ScanTick(ScanTick), .Active(Active)
  );

  // ---------------- clock ----------------
  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, got, want, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // m_n counts clock edges since the last reset; the strobe is visible on
  // every edge count that is a positive multiple of TD.
  int          m_n;
  int          m_owner;     // -1 when nobody is shown
  bit          m_gap;       // inside a blank gap
  int          m_slot;      // ticks consumed by the current owner
  int          m_gapt;      // ticks seen in the current gap
  int          m_ptr;       // last winner
  logic [23:0] m_data;
  logic [5:0]  m_en;

  function automatic int pick(input logic [NS-1:0] r, input int p);
    for (int k = 1; k <= NS; k++) begin
      if (r[(p + k) % NS]) return (p + k) % NS;
    end
    return -1;
  endfunction

  function automatic bit m_tick();
    return (m_n > 0) && (m_n % TD == 0);
  endfunction

  task automatic m_start(input int w);
    m_owner = w;
    m_ptr   = w;
    m_slot  = 0;
  endtask

  // Advance the model by one clock edge using the inputs now applied.
  task automatic model_step();
    bit tick_now;
    int w;
    tick_now = m_tick();
    if (Reset) begin
      m_n = 0; m_owner = -1; m_gap = 0; m_slot = 0; m_gapt = 0;
      m_ptr = NS - 1; m_data = '0; m_en = '0;
      return;
    end
    m_n++;
    if (m_owner >= 0) begin
      m_data = SrcData[24*m_owner +: 24];
      if (!Req[m_owner] || (tick_now && m_slot == HT - 1 && !Lock)) begin
        m_owner = -1; m_gap = 1; m_gapt = 0; m_en = '0;
      end else begin
        m_en = SrcEnables[6*m_owner +: 6];
        if (tick_now && m_slot < HT - 1) m_slot++;
      end
    end else begin
      m_en = '0;
      if (m_gap) begin
        if (tick_now) begin
          m_gapt++;
          if (m_gapt == BT) begin
            m_gap = 0;
            w = pick(Req, m_ptr);
            if (w >= 0) m_start(w);
          end
        end
      end else begin
        w = pick(Req, m_ptr);
        if (w >= 0) m_start(w);
      end
    end
  endtask

  function automatic logic [NS-1:0] m_grant();
    return (m_owner >= 0) ? NS'(1 << m_owner) : '0;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic cycle();
    model_step();
    @(posedge Clock);
    @(negedge Clock);
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    cycle();
    check("rst_grant",  32'(Grant), 32'h0);
    check("rst_data",   32'(Data), 32'h0);
    check("rst_en",     32'(DisplayEnables), 32'h0);
    check("rst_tick",   32'(ScanTick), 32'h0);
    check("rst_active", 32'(Active), 32'h0);
    Reset = 1'b0;
  endtask

  task automatic check_model(input string tag);
    check({tag, "_grant"},  32'(Grant), 32'(m_grant()));
    check({tag, "_active"}, 32'(Active), 32'(m_owner >= 0));
    check({tag, "_data"},   32'(Data), 32'(m_data));
    check({tag, "_en"},     32'(DisplayEnables), 32'(m_en));
    check({tag, "_tick"},   32'(ScanTick), 32'(m_tick()));
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [NS-1:0] req;
    logic          lock;
    int            cycles;
    logic [NS-1:0] grant;
    logic          active;
  } vec_t;

  vec_t vecs[16];
  int   s;

  initial begin
    vecs[0]  = '{4'b0101, 1'b0, 12, 4'b0001, 1'b1};
    vecs[1]  = '{4'b0101, 1'b0,  4, 4'b0000, 1'b0};
    vecs[2]  = '{4'b0101, 1'b0, 12, 4'b0100, 1'b1};
    vecs[3]  = '{4'b0101, 1'b0,  4, 4'b0000, 1'b0};
    vecs[4]  = '{4'b0101, 1'b0, 12, 4'b0001, 1'b1};
    vecs[5]  = '{4'b0101, 1'b0,  4, 4'b0000, 1'b0};
    vecs[6]  = '{4'b0101, 1'b0, 12, 4'b0100, 1'b1};
    vecs[7]  = '{4'b0101, 1'b0,  4, 4'b0000, 1'b0};
    vecs[8]  = '{4'b1000, 1'b0, 12, 4'b1000, 1'b1};
    vecs[9]  = '{4'b1000, 1'b0,  4, 4'b0000, 1'b0};
    vecs[10] = '{4'b1001, 1'b1, 42, 4'b0001, 1'b1};
    vecs[11] = '{4'b1001, 1'b0,  2, 4'b0001, 1'b1};
    vecs[12] = '{4'b1001, 1'b0,  4, 4'b0000, 1'b0};
    vecs[13] = '{4'b1001, 1'b0, 12, 4'b1000, 1'b1};
    vecs[14] = '{4'b1001, 1'b0,  3, 4'b0000, 1'b0};
    vecs[15] = '{4'b0000, 1'b0,  8, 4'b0000, 1'b0};

    Reset = 1'b1;
    Req   = '0;
    Lock  = 1'b0;
    for (int i = 0; i < NS; i++) begin
      SrcData[24*i +: 24]  = 24'hA00000 + 24'(i);
      SrcEnables[6*i +: 6] = 6'(i + 1);
    end
    cycle();
    do_reset();

    // Table: grant / active / strobe period over alternation, lock, idle.
    for (int e = 0; e < 16; e++) begin
      for (int c = 0; c < vecs[e].cycles; c++) begin
        Req  = vecs[e].req;
        Lock = vecs[e].lock;
        cycle();
        check("tbl_grant",  32'(Grant), 32'(vecs[e].grant));
        check("tbl_active", 32'(Active), 32'(vecs[e].active));
        check("tbl_tick",   32'(ScanTick), 32'(m_tick()));
      end
    end

    // Data/enables appear one cycle after Grant; sole source re-granted.
    do_reset();
    Req = 4'b0010;
    SrcData[24 +: 24] = 24'h123456;
    SrcEnables[6 +: 6] = 6'h3F;
    cycle();
    check("lat_grant", 32'(Grant), 32'h2);
    check("lat_en0",   32'(DisplayEnables), 32'h0);
    cycle();
    check("lat_data",  32'(Data), 32'h123456);
    check("lat_en1",   32'(DisplayEnables), 32'h3F);
    repeat (10) cycle();
    check("slot_end_grant", 32'(Grant), 32'h2);
    cycle();
    check("gap_grant", 32'(Grant), 32'h0);
    check("gap_en",    32'(DisplayEnables), 32'h0);
    check("gap_data",  32'(Data), 32'h123456);
    repeat (4) cycle();
    check("regrant", 32'(Grant), 32'h2);

    // Owner drops its request mid-slot: blank on the very next cycle.
    Req = 4'b0000;
    cycle();
    check("drop_grant",  32'(Grant), 32'h0);
    check("drop_active", 32'(Active), 32'h0);
    check("drop_en",     32'(DisplayEnables), 32'h0);

    // Drop coinciding with slot expiry: a single blank period.
    do_reset();
    Req = 4'b0010;
    repeat (12) cycle();
    check("exp_show", 32'(Grant), 32'h2);
    Req = 4'b0000;
    cycle();
    check("exp_blank0", 32'(Grant), 32'h0);
    Req = 4'b0010;
    for (int i = 0; i < 3; i++) begin
      cycle();
      check("exp_blank", 32'(Grant), 32'h0);
    end
    cycle();
    check("exp_regrant", 32'(Grant), 32'h2);

    // Reset while showing, then release with every source requesting.
    SrcEnables[5:0] = 6'h15;
    Reset = 1'b1;
    Req   = 4'b1111;
    cycle();
    check("mid_rst_grant",  32'(Grant), 32'h0);
    check("mid_rst_en",     32'(DisplayEnables), 32'h0);
    check("mid_rst_active", 32'(Active), 32'h0);
    check("mid_rst_tick",   32'(ScanTick), 32'h0);
    Reset = 1'b0;
    cycle();
    check("first_grant", 32'(Grant), 32'h1);
    cycle();
    check("first_en", 32'(DisplayEnables), 32'h15);

    // Randomized run against the reference model.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(15) == 0) Req = 4'($urandom_range(15));
      if ($urandom_range(31) == 0) Lock = ~Lock;
      if ($urandom_range(3) == 0) begin
        s = $urandom_range(NS - 1);
        SrcData[24*s +: 24]  = 24'($urandom);
        SrcEnables[6*s +: 6] = 6'($urandom);
      end
      Reset = ($urandom_range(999) == 0);
      cycle();
      check_model("rnd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
